full_adder_unit: RTL and testbench

- Parameterizable ripple-carry adder built from 1-bit full-adder cells.
- Combinational sum/carry path, plus a registered copy with a valid flag.
- The default WIDTH=1 behaves exactly as a single full adder: inputs a, b, c_in; outputs c_out and sum.
- Used as the basic arithmetic primitive in the game-of-life neighbour-count logic and in adder trees.

---
 rtl/full_adder_unit_pkg.sv | 7 +
 rtl/full_adder_unit_if.sv | 28 ++
 rtl/full_adder_cell.sv | 18 +
 rtl/full_adder_unit.sv | 66 ++++++
 tb/tb_full_adder_unit.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/full_adder_unit_pkg.sv
// full_adder_unit_pkg: shared constants for the ripple-carry adder slice.
//   MAX_WIDTH - widest operand the adder is elaborated for.
package full_adder_unit_pkg;

  localparam int MAX_WIDTH = 64;

endpackage : full_adder_unit_pkg

// File: rtl/full_adder_unit_if.sv
// full_adder_unit_if: operand/result bundle for full_adder_unit.
//   master: drives a, b, c_in, in_valid; observes sum, c_out, sum_q, c_out_q, out_valid.
//   slave : the adder side (the opposite directions).
interface full_adder_unit_if #(
  parameter int WIDTH = 1
) ();

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             in_valid;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic [WIDTH-1:0] sum_q;
  logic             c_out_q;
  logic             out_valid;

  modport master (
    output a, b, c_in, in_valid,
    input  sum, c_out, sum_q, c_out_q, out_valid
  );

  modport slave (
    input  a, b, c_in, in_valid,
    output sum, c_out, sum_q, c_out_q, out_valid
  );

endinterface : full_adder_unit_if

// File: rtl/full_adder_cell.sv
// full_adder_cell: 1-bit combinational full adder.
//   a, b, c_in -> sum (a^b^c_in), c_out (majority of the three).
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);

  logic p;

  // Propagate term shared by sum and carry.
  assign p     = a ^ b;
  assign sum   = p ^ c_in;
  assign c_out = (a & b) | (c_in & p);

endmodule : full_adder_cell

// File: rtl/full_adder_unit.sv
// full_adder_unit: WIDTH-bit ripple-carry adder built from full_adder_cell,
// with a combinational result and a 1-cycle registered copy.
//   clk, rst_n : clock, async active-low reset (clears registered outputs only).
//   bus.a/b/c_in      : operands and carry in.
//   bus.in_valid      : capture the current result on the next rising edge.
//   bus.sum/c_out     : combinational {c_out,sum} = a + b + c_in.
//   bus.sum_q/c_out_q : registered result, held while in_valid is low.
//   bus.out_valid     : high the cycle after an accepted in_valid.
module full_adder_unit
  import full_adder_unit_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  full_adder_unit_if.slave  bus
);

  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("full_adder_unit: WIDTH %0d outside 1..%0d", WIDTH, MAX_WIDTH);
  end

  // carry[i] is the carry into bit i; carry[WIDTH] leaves the MSB.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_c;

  assign carry[0] = bus.c_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_cell u_cell (
      .a     (bus.a[i]),
      .b     (bus.b[i]),
      .c_in  (carry[i]),
      .sum   (sum_c[i]),
      .c_out (carry[i+1])
    );
  end

  assign bus.sum   = sum_c;
  assign bus.c_out = carry[WIDTH];

  logic [WIDTH-1:0] sum_r;
  logic             c_out_r;
  logic             vld_r;

  // Result registers load only on accepted inputs; the valid flag follows
  // in_valid every cycle so it marks exactly one cycle per capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_r   <= '0;
      c_out_r <= 1'b0;
      vld_r   <= 1'b0;
    end else begin
      vld_r <= bus.in_valid;
      if (bus.in_valid) begin
        sum_r   <= sum_c;
        c_out_r <= carry[WIDTH];
      end
    end
  end

  assign bus.sum_q     = sum_r;
  assign bus.c_out_q   = c_out_r;
  assign bus.out_valid = vld_r;

endmodule : full_adder_unit

// File: tb/tb_full_adder_unit.sv
// tb_full_adder_unit: self-checking bench for full_adder_unit at WIDTH 1/4/8/16.
module tb_full_adder_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  full_adder_unit_if #(.WIDTH(1))  bus1  ();
  full_adder_unit_if #(.WIDTH(4))  bus4  ();
  full_adder_unit_if #(.WIDTH(8))  bus8  ();
  full_adder_unit_if #(.WIDTH(16)) bus16 ();

  full_adder_unit #(.WIDTH(1))  u1  (.clk(clk), .rst_n(rst_n), .bus(bus1));
  full_adder_unit #(.WIDTH(4))  u4  (.clk(clk), .rst_n(rst_n), .bus(bus4));
  full_adder_unit #(.WIDTH(8))  u8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
  full_adder_unit #(.WIDTH(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus1.a = '0;  bus1.b = '0;  bus1.c_in = 1'b0;  bus1.in_valid = 1'b1;
    bus4.a = '0;  bus4.b = '0;  bus4.c_in = 1'b0;  bus4.in_valid = 1'b1;
    bus8.a = 8'h3C; bus8.b = 8'h01; bus8.c_in = 1'b0; bus8.in_valid = 1'b1;
    bus16.a = 16'h1234; bus16.b = 16'h1111; bus16.c_in = 1'b1; bus16.in_valid = 1'b1;
    tick();
    tick();
    // in_valid high across edges in reset: nothing may be captured
    checks++;
    if (bus8.sum_q !== 8'h00) begin errors++; $display("FAIL reset_sum_q got %h exp 00", bus8.sum_q); end
    checks++;
    if (bus8.c_out_q !== 1'b0 || bus8.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_ctl got c=%b v=%b exp c=0 v=0", bus8.c_out_q, bus8.out_valid);
    end
    checks++;
    if (bus16.sum_q !== 16'h0 || bus16.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_w16 got %h v=%b exp 0000 v=0", bus16.sum_q, bus16.out_valid);
    end
    // combinational path ignores reset
    checks++;
    if ({bus8.c_out, bus8.sum} !== 9'h03D) begin
      errors++; $display("FAIL reset_comb got %h exp 03d", {bus8.c_out, bus8.sum});
    end
    bus1.in_valid = 1'b0; bus4.in_valid = 1'b0; bus8.in_valid = 1'b0; bus16.in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus8.out_valid !== 1'b0 || bus8.sum_q !== 8'h00) begin
      errors++; $display("FAIL reset_release got %h v=%b exp 00 v=0", bus8.sum_q, bus8.out_valid);
    end
  endtask

  task automatic test_w1_exhaustive();
    logic [1:0] tbl [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      bus1.a = v[0]; bus1.b = v[1]; bus1.c_in = v[2];
      #1;
      checks++;
      if ({bus1.c_out, bus1.sum} !== tbl[i]) begin
        errors++; $display("FAIL w1_in%0d got %b exp %b", i, {bus1.c_out, bus1.sum}, tbl[i]);
      end
    end
  endtask

  task automatic test_w8_wrap();
    bus8.a = 8'hFF; bus8.b = 8'h01; bus8.c_in = 1'b0;
    #1;
    checks++;
    if ({bus8.c_out, bus8.sum} !== 9'h100) begin
      errors++; $display("FAIL w8_ff_plus_1 got %h exp 100", {bus8.c_out, bus8.sum});
    end
    bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.c_in = 1'b1;
    #1;
    checks++;
    if ({bus8.c_out, bus8.sum} !== 9'h1FF) begin
      errors++; $display("FAIL w8_all_ones got %h exp 1ff", {bus8.c_out, bus8.sum});
    end
  endtask

  task automatic test_registered();
    bus8.a = 8'h3C; bus8.b = 8'h0F; bus8.c_in = 1'b1; bus8.in_valid = 1'b1;
    tick();
    bus8.in_valid = 1'b0;
    bus8.a = 8'h80; bus8.b = 8'h80; bus8.c_in = 1'b0;
    checks++;
    if (bus8.sum_q !== 8'h4C || bus8.c_out_q !== 1'b0 || bus8.out_valid !== 1'b1) begin
      errors++; $display("FAIL reg_capture got %h c=%b v=%b exp 4c c=0 v=1",
                         bus8.sum_q, bus8.c_out_q, bus8.out_valid);
    end
    tick();
    checks++;
    if (bus8.sum_q !== 8'h4C || bus8.out_valid !== 1'b0) begin
      errors++; $display("FAIL reg_hold got %h v=%b exp 4c v=0", bus8.sum_q, bus8.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] va [3] = '{4'd1, 4'd7, 4'd15};
    logic [3:0] vb [3] = '{4'd2, 4'd9, 4'd15};
    logic       vc [3] = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      int e;
      bus4.a = va[i]; bus4.b = vb[i]; bus4.c_in = vc[i]; bus4.in_valid = 1'b1;
      e = int'(va[i]) + int'(vb[i]) + int'(vc[i]);
      tick();
      checks++;
      if (bus4.sum_q !== 4'(e % 16) || bus4.c_out_q !== (e >= 16) || bus4.out_valid !== 1'b1) begin
        errors++; $display("FAIL b2b_%0d got %h c=%b v=%b exp %h c=%b v=1",
                           i, bus4.sum_q, bus4.c_out_q, bus4.out_valid, 4'(e % 16), (e >= 16));
      end
    end
    bus4.in_valid = 1'b0;
    tick();
    checks++;
    if (bus4.out_valid !== 1'b0 || bus4.sum_q !== 4'd15) begin
      errors++; $display("FAIL b2b_end got %h v=%b exp f v=0", bus4.sum_q, bus4.out_valid);
    end
  endtask

  task automatic test_reset_mid();
    bus8.a = 8'hA5; bus8.b = 8'h5A; bus8.c_in = 1'b1; bus8.in_valid = 1'b1;
    tick();
    bus8.in_valid = 1'b0;
    checks++;
    if (bus8.sum_q !== 8'h00 || bus8.c_out_q !== 1'b1 || bus8.out_valid !== 1'b1) begin
      errors++; $display("FAIL mid_capture got %h c=%b v=%b exp 00 c=1 v=1",
                         bus8.sum_q, bus8.c_out_q, bus8.out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus8.sum_q !== 8'h00 || bus8.c_out_q !== 1'b0 || bus8.out_valid !== 1'b0) begin
      errors++; $display("FAIL mid_async_clear got %h c=%b v=%b exp 00 c=0 v=0",
                         bus8.sum_q, bus8.c_out_q, bus8.out_valid);
    end
    bus8.a = 8'h10; bus8.b = 8'h20; bus8.c_in = 1'b0;
    #1;
    checks++;
    if ({bus8.c_out, bus8.sum} !== 9'h030) begin
      errors++; $display("FAIL mid_comb_in_reset got %h exp 030", {bus8.c_out, bus8.sum});
    end
    rst_n = 1'b1;
    bus8.in_valid = 1'b1;
    tick();
    bus8.in_valid = 1'b0;
    checks++;
    if (bus8.sum_q !== 8'h30 || bus8.out_valid !== 1'b1) begin
      errors++; $display("FAIL mid_first_capture got %h v=%b exp 30 v=1", bus8.sum_q, bus8.out_valid);
    end
  endtask

  task automatic test_random16();
    logic [15:0] held_sum = '0;
    logic        held_c   = 1'b0;
    int          bad      = 0;
    for (int i = 0; i < 1000; i++) begin
      logic [16:0] ref_v;
      logic        v;
      bus16.a = 16'($urandom); bus16.b = 16'($urandom);
      bus16.c_in = 1'($urandom); v = 1'($urandom);
      bus16.in_valid = v;
      ref_v = {1'b0, bus16.a} + {1'b0, bus16.b} + 17'(bus16.c_in);
      #1;
      checks++;
      if ({bus16.c_out, bus16.sum} !== ref_v) begin
        errors++; bad++;
        if (bad < 10) $display("FAIL rnd_comb_%0d got %h exp %h", i, {bus16.c_out, bus16.sum}, ref_v);
      end
      if (v) begin held_sum = ref_v[15:0]; held_c = ref_v[16]; end
      tick();
      checks++;
      if (bus16.sum_q !== held_sum || bus16.c_out_q !== held_c || bus16.out_valid !== v) begin
        errors++; bad++;
        if (bad < 10) $display("FAIL rnd_reg_%0d got %h c=%b v=%b exp %h c=%b v=%b",
                               i, bus16.sum_q, bus16.c_out_q, bus16.out_valid, held_sum, held_c, v);
      end
    end
    bus16.in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_w1_exhaustive();
    test_w8_wrap();
    test_registered();
    test_back_to_back();
    test_reset_mid();
    test_random16();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_full_adder_unit
